clk_meas: RTL and testbench

CLK_MEAS -- requirements
Module: clk_meas

---
 rtl/clk_meas_pkg.sv | 20 ++
 rtl/sig_sync_edge.sv | 76 +++++++
 rtl/clk_meas.sv | 152 +++++++++++++++
 tb/tb_clk_meas.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_meas_pkg
//  Description : Shared constants for the clock/period measurement block:
//                FSM state encoding and deglitch filter length.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_meas_pkg;

    // Measurement FSM state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_arm   = 2'd1;
    localparam logic [1:0] c_st_count = 2'd2;

    // Consecutive cycles the synced input must hold a new value before the
    // filtered level follows it (only used when CLK_MEAS_FILTER_EN is set)
    localparam int c_filt_len = 3;

endpackage
`default_nettype wire

// File: rtl/sig_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sig_sync_edge
//  Description : Synchronizes an asynchronous input into the clk domain and
//                emits a one-cycle pulse on each rising edge of the
//                synchronized (optionally deglitched) level.
//                Macro CLK_MEAS_FILTER_EN inserts a deglitch filter between
//                the synchronizer and the edge detector.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous active-high reset
//                sig_in - asynchronous input
//                rise   - one-cycle rising-edge pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module sig_sync_edge #(
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);
    import clk_meas_pkg::*;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_synced;
    logic                   w_level;
    logic                   r_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

`ifdef CLK_MEAS_FILTER_EN
    localparam int c_fcnt_w = $clog2(c_filt_len);
    localparam logic [c_fcnt_w-1:0] c_fcnt_last = c_fcnt_w'(c_filt_len - 1);

    // Counts consecutive cycles the synced value differs from the filtered
    // level; the new value is accepted combinationally on the last of those
    // cycles so the filter adds only c_filt_len-1 cycles of latency.
    logic [c_fcnt_w-1:0] r_fcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fcnt <= '0;
        end else if ((w_synced != r_level) && (r_fcnt != c_fcnt_last)) begin
            r_fcnt <= r_fcnt + c_fcnt_w'(1);
        end else begin
            r_fcnt <= '0;
        end
    end

    assign w_level = ((w_synced != r_level) && (r_fcnt == c_fcnt_last)) ? w_synced : r_level;
`else
    assign w_level = w_synced;
`endif

    // r_level is the previous level seen by the edge detector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= 1'b0;
        end else begin
            r_level <= w_level;
        end
    end

    assign rise = w_level & ~r_level;

endmodule
`default_nettype wire

// File: rtl/clk_meas.sv
`default_nettype none
// ============================================================================
//  Module      : clk_meas
//  Description : Measures the period of a slow asynchronous signal in clk
//                cycles and presents each result on a valid/ready handshake.
//                Optional deglitch filter enabled by macro CLK_MEAS_FILTER_EN.
//  Ports       : clk      - clock, rising edge
//                reset    - asynchronous active-high reset
//                ena      - measurement enable
//                sig_in   - asynchronous signal to measure
//                period   - measured period (clk cycles)
//                valid    - period holds an unconsumed result
//                ready    - consumer accepts result while valid is high
//                missed   - sticky: a result was dropped while valid was high
//                overflow - one-cycle pulse: counter saturated with no edge
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_meas #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ena,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 valid,
    input  logic                 ready,
    output logic                 missed,
    output logic                 overflow
);
    import clk_meas_pkg::*;

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic                 w_rise;
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_cnt_load;
    logic                 w_cnt_inc;
    logic                 w_cnt_clr;
    logic                 w_result;
    logic                 w_ovf;
    logic [CNT_WIDTH-1:0] r_period;
    logic                 r_valid;
    logic                 r_missed;
    logic                 r_overflow;

    sig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (w_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_result    = 1'b0;
        w_ovf       = 1'b0;
        if (!ena) begin
            // Disable wins over everything: no result, counter cleared
            w_state_nxt = c_st_idle;
            w_cnt_clr   = 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    w_state_nxt = c_st_arm;
                end
                c_st_arm: begin
                    if (w_rise) begin
                        w_state_nxt = c_st_count;
                        w_cnt_load  = 1'b1;
                    end
                end
                c_st_count: begin
                    // An edge on the saturation cycle is still a valid result
                    if (w_rise) begin
                        w_result   = 1'b1;
                        w_cnt_load = 1'b1;
                    end else if (r_cnt == c_cnt_max) begin
                        w_ovf       = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = c_st_arm;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_load) begin
            r_cnt <= CNT_WIDTH'(1);
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    // Result hold register: a new result is taken only when the slot is
    // free or being drained this cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_missed   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_ovf;
            if (w_result) begin
                if (!r_valid || ready) begin
                    r_period <= r_cnt;
                    r_valid  <= 1'b1;
                    r_missed <= 1'b0;
                end else begin
                    r_missed <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid  <= 1'b0;
                r_missed <= 1'b0;
            end
        end
    end

    assign period   = r_period;
    assign valid    = r_valid;
    assign missed   = r_missed;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_clk_meas.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_meas
//  Description : Self-checking bench for clk_meas. Two instances (16-bit and
//                4-bit counters) share stimulus. Expected results are derived
//                from the times of the driven sig_in rising edges: a result
//                equals the distance between consecutive edges and appears a
//                fixed latency after the closing edge; a gap larger than the
//                counter maximum yields an overflow pulse instead.
//                Honours CLK_MEAS_FILTER_EN (extra latency + glitch test).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_meas;

    localparam int S = 2;
`ifdef CLK_MEAS_FILTER_EN
    localparam int L = S + 2;
`else
    localparam int L = S;
`endif

    logic        clk;
    logic        reset;
    logic        ena;
    logic        sig_in;
    logic        ready;
    logic [15:0] period;
    logic        valid;
    logic        missed;
    logic        overflow;
    logic [3:0]  period4;
    logic        valid4;
    logic        missed4;
    logic        overflow4;

    int n_assert = 0;
    int n_fail   = 0;

    int ev_v16[int];
    int ev_v4[int];
    int ev_o16[int];
    int ev_o4[int];

    clk_meas #(.CNT_WIDTH(16), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .ena(ena), .sig_in(sig_in),
        .period(period), .valid(valid), .ready(ready),
        .missed(missed), .overflow(overflow)
    );

    clk_meas #(.CNT_WIDTH(4), .SYNC_STAGES(S)) dut4 (
        .clk(clk), .reset(reset), .ena(ena), .sig_in(sig_in),
        .period(period4), .valid(valid4), .ready(ready),
        .missed(missed4), .overflow(overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold(input logic v, input int n, input bit chk0);
        for (int i = 0; i < n; i++) begin
            sig_in = v;
            tick();
            if (chk0) chk("no_valid", valid, 0);
        end
    endtask

    task automatic prep();
        reset  = 1'b1;
        sig_in = 1'b0;
        ena    = 1'b0;
        ready  = 1'b1;
        tick();
        reset = 1'b0;
        ena   = 1'b1;
        tick();
        tick();
        tick();
    endtask

    // mode 0: square wave period 10; 1: random halves 3..12;
    // 2: single pulse then low; 3: periods alternating 15 and 16
    task automatic run_seg(input int mode, input int n);
        logic w[];
        int   rises[$];
        int   idx;
        int   half;
        int   k3;
        logic lvl;
        int   mx;
        int   last;
        bit   counting;
        int   p;
        w = new[n];
        ev_v16.delete(); ev_v4.delete(); ev_o16.delete(); ev_o4.delete();
        idx = 0;
        k3  = 0;
        lvl = 1'b1;
        for (int i = 0; i < 6; i++) w[i] = 1'b0;
        idx = 6;
        while (idx < n) begin
            case (mode)
                0:       half = 5;
                1:       half = int'($urandom_range(12, 3));
                2:       half = lvl ? 5 : n;
                default: begin half = (k3 == 0) ? 7 : 8; k3 = (k3 + 1) % 4; end
            endcase
            for (int j = 0; j < half && idx < n; j++) begin
                w[idx] = lvl;
                idx++;
            end
            lvl = ~lvl;
        end
        for (int i = 1; i < n; i++) if (w[i] && !w[i-1]) rises.push_back(i);

        for (int k = 0; k < 2; k++) begin
            mx = (k == 0) ? 65535 : 15;
            counting = 1'b0;
            last = 0;
            foreach (rises[r]) begin
                p = rises[r];
                if (counting && (p - last) <= mx) begin
                    if (k == 0) ev_v16[p + L] = p - last;
                    else        ev_v4[p + L]  = p - last;
                end else begin
                    if (counting) begin
                        if (k == 0) ev_o16[last + L + mx] = 1;
                        else        ev_o4[last + L + mx]  = 1;
                    end
                    counting = 1'b1;
                end
                last = p;
            end
            if (counting) begin
                if (k == 0) ev_o16[last + L + mx] = 1;
                else        ev_o4[last + L + mx]  = 1;
            end
        end

        for (int c = 0; c < n; c++) begin
            sig_in = w[c];
            tick();
            chk("valid16", valid, ev_v16.exists(c));
            if (ev_v16.exists(c)) chk("period16", period, ev_v16[c]);
            chk("ovf16", overflow, ev_o16.exists(c));
            chk("missed16", missed, 0);
            chk("valid4", valid4, ev_v4.exists(c));
            if (ev_v4.exists(c)) chk("period4", period4, ev_v4[c]);
            chk("ovf4", overflow4, ev_o4.exists(c));
        end
        sig_in = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        ena    = 1'b0;
        sig_in = 1'b0;
        ready  = 1'b0;
        @(negedge clk);
        chk("rst_period", period, 0);
        chk("rst_valid", valid, 0);
        chk("rst_missed", missed, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_period4", period4, 0);
        chk("rst_valid4", valid4, 0);

        prep(); run_seg(0, 120);
        prep(); run_seg(1, 400);
        prep(); run_seg(2, 60);
        prep(); run_seg(3, 200);

        // Back-pressure: three period-8 results while ready is low
        prep();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hold(1'b1, 4, 1'b0);
            hold(1'b0, 4, 1'b0);
        end
        hold(1'b0, 6, 1'b0);
        chk("bp_valid", valid, 1);
        chk("bp_period", period, 8);
        chk("bp_missed", missed, 1);
        ready = 1'b1;
        tick();
        chk("bp_acc_valid", valid, 0);
        chk("bp_acc_missed", missed, 0);

        // Reset mid-count with counter at 7 and a pending result
        prep();
        ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hold(1'b1, 4, 1'b0);
            hold(1'b0, 6, 1'b0);
        end
        sig_in = 1'b1;
        tick();
        hold(1'b1, 3, 1'b0);
        hold(1'b0, L + 3, 1'b0);
        chk("pre_rst_valid", valid, 1);
        chk("pre_rst_missed", missed, 1);
        reset = 1'b1;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_period", period, 0);
        tick();
        reset = 1'b0;
        ready = 1'b1;
        chk("rst_mid_valid", valid, 0);
        chk("rst_mid_period", period, 0);
        chk("rst_mid_missed", missed, 0);
        chk("rst_mid_ovf", overflow, 0);
        hold(1'b0, 3, 1'b1);
        hold(1'b1, 4, 1'b1);
        hold(1'b0, 16, 1'b1);
        hold(1'b1, L, 1'b1);
        sig_in = 1'b1;
        tick();
        chk("fresh_valid", valid, 1);
        chk("fresh_period", period, 20);
        hold(1'b1, 2, 1'b0);
        hold(1'b0, 6, 1'b0);

        // ena dropped while a result is pending
        prep();
        ready = 1'b0;
        hold(1'b1, 4, 1'b0);
        hold(1'b0, 6, 1'b0);
        hold(1'b1, 4, 1'b0);
        hold(1'b0, 8, 1'b0);
        chk("ena_pre_valid", valid, 1);
        chk("ena_pre_period", period, 10);
        ena = 1'b0;
        hold(1'b0, 3, 1'b0);
        chk("ena_off_valid", valid, 1);
        chk("ena_off_period", period, 10);
        ready = 1'b1;
        tick();
        chk("ena_off_acc", valid, 0);
        ena = 1'b1;
        tick();
        hold(1'b1, 4, 1'b1);
        hold(1'b0, 5, 1'b1);
        hold(1'b1, L, 1'b1);
        sig_in = 1'b1;
        tick();
        chk("ena_re_valid", valid, 1);
        chk("ena_re_period", period, 9);
        hold(1'b0, 6, 1'b0);

`ifdef CLK_MEAS_FILTER_EN
        // 2-cycle glitch between two genuine edges 12 apart
        prep();
        hold(1'b1, 6, 1'b1);
        hold(1'b0, 2, 1'b1);
        hold(1'b1, 2, 1'b1);
        hold(1'b0, 2, 1'b1);
        hold(1'b1, L, 1'b1);
        sig_in = 1'b1;
        tick();
        chk("flt_valid", valid, 1);
        chk("flt_period", period, 12);
        hold(1'b1, 5 - L, 1'b0);
        hold(1'b0, 6, 1'b0);
        hold(1'b1, L, 1'b0);
        sig_in = 1'b1;
        tick();
        chk("flt_sq_valid", valid, 1);
        chk("flt_sq_period", period, 12);
        hold(1'b0, 6, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
